// File: rtl/tristate_bus_ctrl.sv
// Half-duplex pad controller: guarded write drive windows and
// timed read sampling, one request in flight at a time.
module tristate_bus_ctrl #(
    parameter int WIDTH = 8,
    parameter int GUARD = 1,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data
);

    localparam int CW = $clog2(GUARD + HOLD + 1);
    localparam logic [CW-1:0] G_LOAD = CW'(GUARD - 1);
    localparam logic [CW-1:0] H_LOAD = CW'(HOLD - 1);
    localparam logic [CW-1:0] W_LOAD = CW'(GUARD + HOLD - 1);

    typedef enum logic [2:0] {
        IDLE,
        GUARD_ON,
        DRIVE,
        GUARD_OFF,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] rsp_q;
    logic             cnt_done;

    assign cnt_done = (cnt == '0);
    assign rsp_data = rsp_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        bus_oe    = 1'b0;
        bus_out   = '0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_write) begin
                        state_nxt = GUARD_ON;
                        cnt_nxt   = G_LOAD;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = W_LOAD;
                    end
                end
            end
            GUARD_ON: begin
                bus_out = data_q;
                if (cnt_done) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = H_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DRIVE: begin
                bus_oe  = 1'b1;
                bus_out = data_q;
                if (cnt_done) begin
                    state_nxt = GUARD_OFF;
                    cnt_nxt   = G_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GUARD_OFF: begin
                bus_out = data_q;
                if (cnt_done) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WAIT: begin
                if (cnt_done) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            data_q <= '0;
            rsp_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req_valid) begin
                data_q <= req_data;
            end
            // Reads sample the pad raw so undriven bits reach the consumer
            if (state == WAIT && cnt_done) begin
                rsp_q <= bus_in;
            end
            if (state == GUARD_OFF && cnt_done) begin
                rsp_q <= data_q;
            end
        end
    end

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Scoreboard bench for tristate_bus_ctrl: cycle-exact pad timing
// plus in-order response checking at the handshake.
module tb_tristate_bus_ctrl;

    localparam int W = 8;
    localparam int G = 1;
    localparam int H = 2;
    localparam logic [W-1:0] JUNK = 8'h5A;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [W-1:0] req_data;
    logic [W-1:0] bus_in;
    logic [W-1:0] bus_out;
    logic         bus_oe;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;

    logic [W-1:0] sb[$];
    int           checks;
    int           failures;
    int           nrsp;

    tristate_bus_ctrl #(.WIDTH(W), .GUARD(G), .HOLD(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_data  (req_data),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            nrsp++;
            if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
            else chk("sb_data", 32'(rsp_data), 32'(sb.pop_front()));
        end
    end

    task automatic start_req(input bit w, input logic [W-1:0] d,
                             input logic [W-1:0] bv);
        chk("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_data  = d;
        bus_in    = JUNK;
        sb.push_back(w ? d : bv);
    endtask

    task automatic follow(input bit w, input logic [W-1:0] d,
                          input logic [W-1:0] bv, input int stall,
                          input bit b2b, input logic [W-1:0] nd);
        int n;
        logic [W-1:0] e;
        n = w ? 2 * G + H : G + H;
        e = w ? d : bv;
        @(posedge clk); #1;
        if (b2b) begin
            req_write = 1'b1;
            req_data  = nd;
            sb.push_back(nd);
        end else begin
            req_valid = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            chk("busy_ready", 32'(req_ready), 32'd0);
            chk("busy_rspv", 32'(rsp_valid), 32'd0);
            if (w) begin
                chk("wr_oe", 32'(bus_oe), 32'(k >= G && k < G + H));
                chk("wr_out", 32'(bus_out), 32'(d));
            end else begin
                chk("rd_oe", 32'(bus_oe), 32'd0);
                chk("rd_out", 32'(bus_out), 32'd0);
                if (k == n - 1) bus_in = bv;
            end
            @(posedge clk); #1;
        end
        bus_in = JUNK;
        for (int s = 0; s < stall; s++) begin
            chk("stall_rspv", 32'(rsp_valid), 32'd1);
            chk("stall_data", 32'(rsp_data), 32'(e));
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_oe", 32'(bus_oe), 32'd0);
            if (!b2b) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_data  = 8'hEE;
            end
            @(posedge clk); #1;
        end
        if (!b2b) req_valid = 1'b0;
        chk("resp_rspv", 32'(rsp_valid), 32'd1);
        chk("resp_data", 32'(rsp_data), 32'(e));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post_rspv", 32'(rsp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
        chk("post_oe", 32'(bus_oe), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] zv;
        zv        = 'z;
        checks    = 0;
        failures  = 0;
        nrsp      = 0;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_data  = '0;
        bus_in    = JUNK;
        rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_oe", 32'(bus_oe), 32'd0);
        chk("rst_out", 32'(bus_out), 32'd0);
        chk("rst_rspv", 32'(rsp_valid), 32'd0);
        chk("rst_rspd", 32'(rsp_data), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;

        start_req(1'b1, 8'hA5, JUNK);
        follow(1'b1, 8'hA5, JUNK, 0, 1'b0, 8'h00);
        start_req(1'b0, 8'h00, 8'h3C);
        follow(1'b0, 8'h00, 8'h3C, 0, 1'b0, 8'h00);
        start_req(1'b0, 8'h00, zv);
        follow(1'b0, 8'h00, zv, 0, 1'b0, 8'h00);
        start_req(1'b0, 8'h00, 8'h81);
        follow(1'b0, 8'h00, 8'h81, 5, 1'b1, 8'hC3);
        follow(1'b1, 8'hC3, JUNK, 0, 1'b0, 8'h00);
        start_req(1'b1, 8'h0F, JUNK);
        follow(1'b1, 8'h0F, JUNK, 2, 1'b0, 8'h00);

        start_req(1'b1, 8'h96, JUNK);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_drive_oe", 32'(bus_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_oe", 32'(bus_oe), 32'd0);
        chk("arst_out", 32'(bus_out), 32'd0);
        chk("arst_rspv", 32'(rsp_valid), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd1);
        void'(sb.pop_back());
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("after_rst_rspv", 32'(rsp_valid), 32'd0);
            chk("after_rst_ready", 32'(req_ready), 32'd1);
        end
        rsp_ready = 1'b0;

        start_req(1'b1, 8'h6E, JUNK);
        follow(1'b1, 8'h6E, JUNK, 0, 1'b0, 8'h00);

        repeat (2) @(posedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        chk("rsp_count", 32'(nrsp), 32'd7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
